// File: rtl/litedram_native_bist_if.sv
// LiteDRAM native user port: command, write-data and read-data handshakes.
// The BIST engine is the master; litedram_core (or a model of it) is the slave.
interface litedram_native_bist_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 256
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                wdata_valid;
  logic                wdata_ready;
  logic [DATA_W/8-1:0] wdata_we;
  logic [DATA_W-1:0]   wdata_data;
  logic                rdata_valid;
  logic                rdata_ready;
  logic [DATA_W-1:0]   rdata_data;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, wdata_valid, wdata_we, wdata_data, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata_data
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, wdata_valid, wdata_we, wdata_data, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata_data
  );
endinterface

// File: rtl/litedram_native_bist.sv
// Built-in self-test for one LiteDRAM native port: writes an address-derived pattern
// over a range, reads it back with pipelined reads and counts mismatching words.
module litedram_native_bist #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ERR_W     = 16
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [CNT_W-1:0]  progress,
  litedram_native_bist_if.master native
);
  localparam int unsigned LANES = DATA_W / 32;
  localparam int unsigned OUT_W = 4;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       seed_q;
  logic [CNT_W-1:0]  cmd_cnt_q;
  logic [CNT_W-1:0]  dat_cnt_q;
  logic [OUT_W-1:0]  outst_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] first_q;
  logic              pass_q;

  logic              cmd_left, dat_left;
  logic              cmd_fire, wd_fire, rd_fire, rd_cmd_fire, mismatch;
  logic [ADDR_W-1:0] dat_addr;
  logic [DATA_W-1:0] dat_pattern;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr,
                                                input logic [31:0]       s);
    logic [DATA_W-1:0] w;
    logic [31:0]       a32;
    a32 = 32'(addr);
    w   = '0;
    for (int i = 0; i < int'(LANES); i++) w[i*32 +: 32] = (a32 + 32'(i)) ^ s;
    return w;
  endfunction

  // dat_cnt_q counts written beats in WRITE and checked words in READ
  assign cmd_left    = (cmd_cnt_q != count_q);
  assign dat_left    = (dat_cnt_q != count_q);
  assign dat_addr    = base_q + ADDR_W'(dat_cnt_q);
  assign dat_pattern = pattern(dat_addr, seed_q);
  assign cmd_fire    = native.cmd_valid && native.cmd_ready;
  assign wd_fire     = (state_q == StWrite) && dat_left && native.wdata_ready;
  assign rd_cmd_fire = cmd_fire && (state_q == StRead);
  assign rd_fire     = (state_q == StRead) && (outst_q != '0) && native.rdata_valid;
  assign mismatch    = rd_fire && (native.rdata_data != dat_pattern);

  always_comb begin
    state_d            = state_q;
    native.cmd_valid   = 1'b0;
    native.cmd_we      = 1'b0;
    native.cmd_addr    = base_q + ADDR_W'(cmd_cnt_q);
    native.wdata_valid = 1'b0;
    native.wdata_we    = '0;
    native.wdata_data  = dat_pattern;
    native.rdata_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (mode == 2'd1) ? StRead : StWrite;
      end
      StWrite: begin
        native.wdata_valid = dat_left;
        native.wdata_we    = dat_left ? '1 : '0;
        native.cmd_we      = 1'b1;
        // a write command may only catch up with data already sent or being sent now
        native.cmd_valid   = cmd_left && ((cmd_cnt_q < dat_cnt_q) || wd_fire);
        if (!cmd_left && !dat_left) begin
          state_d = ((mode_q != 2'd0) && (count_q != '0)) ? StRead : StDone;
        end
      end
      StRead: begin
        native.cmd_valid   = cmd_left && (outst_q < OUT_W'(MAX_OUTST));
        native.rdata_ready = (outst_q != '0);
        if (!dat_left) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      base_q    <= '0;
      count_q   <= '0;
      seed_q    <= '0;
      cmd_cnt_q <= '0;
      dat_cnt_q <= '0;
      outst_q   <= '0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        if (start) begin
          mode_q    <= mode;
          base_q    <= base_addr;
          count_q   <= word_count;
          seed_q    <= seed;
          cmd_cnt_q <= '0;
          dat_cnt_q <= '0;
          outst_q   <= '0;
          err_q     <= '0;
          first_q   <= '0;
          pass_q    <= 1'b0;
        end
      end else begin
        if (cmd_fire) cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
        if (wd_fire || rd_fire) dat_cnt_q <= dat_cnt_q + CNT_W'(1);
        if (rd_cmd_fire && !rd_fire) begin
          outst_q <= outst_q + OUT_W'(1);
        end else if (!rd_cmd_fire && rd_fire) begin
          outst_q <= outst_q - OUT_W'(1);
        end
        if (mismatch) begin
          if (err_q != '1) err_q <= err_q + ERR_W'(1);
          if (err_q == '0) first_q <= dat_addr;
        end
        if ((state_q == StWrite) && (state_d == StRead)) begin
          cmd_cnt_q <= '0;
          dat_cnt_q <= '0;
        end
        // err_q saturates rather than wraps, so nonzero still means a failure
        if ((state_q != StDone) && (state_d == StDone)) pass_q <= (err_q == '0);
      end
    end
  end

  assign busy           = (state_q == StWrite) || (state_q == StRead);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign first_err_addr = first_q;
  assign progress       = dat_cnt_q;
endmodule
